// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access sizes and the bridge FSM states.
package lsu_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2,
        SIZE_BAD  = 2'd3
    } size_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } state_t;

endpackage

// File: rtl/lsu_load_align.sv
// Selects the addressed byte/half lane of an SRAM word and sign- or zero-extends it.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Lane extraction followed by extension; word loads pass straight through.
    always_comb begin
        byte_v = rdata[{lane, 3'b000} +: 8];
        half_v = lane[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            SIZE_BYTE: data = {{24{sign_ext & byte_v[7]}}, byte_v};
            SIZE_HALF: data = {{16{sign_ext & half_v[15]}}, half_v};
            default:   data = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_sram_bridge.sv
// Bridges one core load/store request onto a single-port synchronous SRAM with
// byte enables and a fixed read latency; all outputs come straight from flops.
module lsu_sram_bridge
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int RD_LAT = 1
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              done,
    output logic [31:0]       rsp_rdata,
    output logic              misalign_err,
    output logic              range_err,
    output logic              sram_en,
    output logic              sram_we,
    output logic [3:0]        sram_be,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata
);

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [1:0]        size_q, size_d;
    logic              signed_q, signed_d;
    logic [1:0]        lane_q, lane_d;

    logic              done_d, misalign_d, range_d, en_d, we_d;
    logic [31:0]       rdata_d, wdata_d;
    logic [3:0]        be_d;
    logic [ADDR_W-1:0] addr_d;

    logic              req_misalign, req_range;
    logic [3:0]        req_be;
    logic [31:0]       req_wdata_rep;
    logic [31:0]       load_word;

    // Decode the incoming request: lane enables, replicated store data, alignment.
    // NOTE: every variable gets a value before the case so no path leaves one unassigned (no latch).
    always_comb begin
        req_be        = 4'b1111;
        req_wdata_rep = req_wdata;
        req_misalign  = 1'b0;
        case (req_size)
            SIZE_BYTE: begin
                req_be        = 4'b0001 << req_addr[1:0];
                req_wdata_rep = {4{req_wdata[7:0]}};
            end
            SIZE_HALF: begin
                req_be        = req_addr[1] ? 4'b1100 : 4'b0011;
                req_wdata_rep = {2{req_wdata[15:0]}};
                req_misalign  = req_addr[0];
            end
            SIZE_WORD: req_misalign = |req_addr[1:0];
            default:   req_misalign = 1'b1;
        endcase
    end

    assign req_range = (req_addr >> (ADDR_W + 2)) != 32'd0;

    lsu_load_align u_align (
        .rdata    (sram_rdata),
        .lane     (lane_q),
        .size     (size_q),
        .sign_ext (signed_q),
        .data     (load_word)
    );

    // Next state and next value of every registered output.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        size_d     = size_q;
        signed_d   = signed_q;
        lane_d     = lane_q;
        done_d     = 1'b0;
        misalign_d = 1'b0;
        range_d    = 1'b0;
        rdata_d    = rsp_rdata;
        en_d       = sram_en;
        we_d       = sram_we;
        be_d       = sram_be;
        addr_d     = sram_addr;
        wdata_d    = sram_wdata;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (req_misalign || req_range) begin
                        state_d    = ERR;
                        done_d     = 1'b1;
                        misalign_d = req_misalign;
                        range_d    = req_range;
                        rdata_d    = 32'd0;
                    end else begin
                        state_d  = ISSUE;
                        en_d     = 1'b1;
                        we_d     = req_write;
                        be_d     = req_be;
                        addr_d   = req_addr[ADDR_W+1:2];
                        wdata_d  = req_wdata_rep;
                        size_d   = req_size;
                        signed_d = req_signed;
                        lane_d   = req_addr[1:0];
                    end
                end
            end
            ISSUE: begin
                en_d = 1'b0;
                we_d = 1'b0;
                // sram_we still holds this access's direction during ISSUE.
                if (sram_we) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = WAIT;
                    cnt_d   = 2'(RD_LAT - 1);
                end
            end
            WAIT: begin
                if (cnt_q == 2'd0) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    rdata_d = load_word;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            default: state_d = IDLE;  // DONE and ERR: the pulse lasts one cycle
        endcase
    end

    // State, counter, captured request fields and all outputs.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 2'd0;
            size_q       <= 2'd0;
            signed_q     <= 1'b0;
            lane_q       <= 2'd0;
            done         <= 1'b0;
            misalign_err <= 1'b0;
            range_err    <= 1'b0;
            rsp_rdata    <= 32'd0;
            sram_en      <= 1'b0;
            sram_we      <= 1'b0;
            sram_be      <= 4'd0;
            sram_addr    <= '0;
            sram_wdata   <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            lane_q       <= lane_d;
            done         <= done_d;
            misalign_err <= misalign_d;
            range_err    <= range_d;
            rsp_rdata    <= rdata_d;
            sram_en      <= en_d;
            sram_we      <= we_d;
            sram_be      <= be_d;
            sram_addr    <= addr_d;
            sram_wdata   <= wdata_d;
        end
    end

endmodule
